de0ec8_dram_arb: RTL

Three-requester arbiter sharing the single SDRAM controller command port on the de0ec8 board between the VGA line-fetch engine and two general masters (CPU side and debug/UART loader). It sits between the requesters and the SDRAM controller that drives DRAM_*. It grants one command at a time, latches it, forwards it, and routes read data back to the granted requester. Refresh and the SDRAM protocol stay in the SDRAM controller.

---
 rtl/de0ec8_dram_arb.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/de0ec8_dram_arb.sv
// rtl/de0ec8_dram_arb.sv - three-requester arbiter for the de0ec8 SDRAM controller command port
// Optional macro DE0EC8_ARB_STAT_EN adds the STAT_G0/STAT_G1/STAT_G2 grant counters.
module de0ec8_dram_arb #(
    parameter int VID_MAX    = 4,
    parameter int RD_TIMEOUT = 255
) (
    input  logic        CLK50,
    input  logic        RST_N_r,
    input  logic        R0_REQ,
    input  logic        R0_WR,
    input  logic [23:0] R0_ADDR,
    input  logic [15:0] R0_WDATA,
    output logic        R0_ACK,
    output logic        R0_RVALID,
    input  logic        R1_REQ,
    input  logic        R1_WR,
    input  logic [23:0] R1_ADDR,
    input  logic [15:0] R1_WDATA,
    output logic        R1_ACK,
    output logic        R1_RVALID,
    input  logic        R2_REQ,
    input  logic        R2_WR,
    input  logic [23:0] R2_ADDR,
    input  logic [15:0] R2_WDATA,
    output logic        R2_ACK,
    output logic        R2_RVALID,
    output logic [15:0] R_RDATA,
    output logic        MEM_REQ,
    output logic        MEM_WR,
    output logic [23:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic        MEM_RVALID,
    input  logic [15:0] MEM_RDATA,
`ifdef DE0EC8_ARB_STAT_EN
    output logic [15:0] STAT_G0,
    output logic [15:0] STAT_G1,
    output logic [15:0] STAT_G2,
`endif
    output logic        ARB_ERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RDWAIT = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_grant;
    logic        r_rr_r2;      // 1: R2 wins the next R1/R2 tie, 0: R1 wins
    logic [3:0]  r_vid_cnt;
    logic [7:0]  r_to_cnt;
    logic        r_mem_req;
    logic        r_mem_wr;
    logic [23:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_arb_err;

    logic        w_low;
    logic        w_any;
    logic        w_vid_cap;
    logic [1:0]  w_sel;
    logic        w_sel_wr;
    logic [23:0] w_sel_addr;
    logic [15:0] w_sel_wdata;
    logic        w_ack_ok;
    logic        w_rv_ok;

    assign w_low     = R1_REQ | R2_REQ;
    assign w_any     = R0_REQ | w_low;
    assign w_vid_cap = (r_vid_cnt == 4'(VID_MAX));

    // Winner selection: video first unless it has used up its burst while a low request waits
    always_comb begin
        w_sel = 2'd0;
        if (R0_REQ && !(w_vid_cap && w_low)) begin
            w_sel = 2'd0;
        end else if (R1_REQ && R2_REQ) begin
            w_sel = r_rr_r2 ? 2'd2 : 2'd1;
        end else if (R1_REQ) begin
            w_sel = 2'd1;
        end else if (R2_REQ) begin
            w_sel = 2'd2;
        end
    end

    // Command mux feeding the latch from the selected requester
    always_comb begin
        w_sel_wr    = R0_WR;
        w_sel_addr  = R0_ADDR;
        w_sel_wdata = R0_WDATA;
        case (w_sel)
            2'd1: begin
                w_sel_wr    = R1_WR;
                w_sel_addr  = R1_ADDR;
                w_sel_wdata = R1_WDATA;
            end
            2'd2: begin
                w_sel_wr    = R2_WR;
                w_sel_addr  = R2_ADDR;
                w_sel_wdata = R2_WDATA;
            end
            default: begin
                w_sel_wr    = R0_WR;
                w_sel_addr  = R0_ADDR;
                w_sel_wdata = R0_WDATA;
            end
        endcase
    end

    // Arbitration FSM: latch winner, hold command until accepted, wait for read data
    always_ff @(posedge CLK50 or negedge RST_N_r) begin
        if (!RST_N_r) begin
            r_state     <= S_IDLE;
            r_grant     <= 2'd0;
            r_rr_r2     <= 1'b0;
            r_vid_cnt   <= 4'd0;
            r_to_cnt    <= 8'd0;
            r_mem_req   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= 24'd0;
            r_mem_wdata <= 16'd0;
            r_arb_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_sel;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= w_sel_wr;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_state     <= S_ISSUE;
                        if (w_sel == 2'd0) begin
                            // Only video grants that starve a low requester count toward the cap
                            if (w_low && !w_vid_cap) begin
                                r_vid_cnt <= r_vid_cnt + 4'd1;
                            end
                        end else begin
                            r_vid_cnt <= 4'd0;
                            r_rr_r2   <= (w_sel == 2'd1);
                        end
                    end
                end
                S_ISSUE: begin
                    if (MEM_ACK) begin
                        r_mem_req <= 1'b0;
                        if (r_mem_wr) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_to_cnt <= 8'd0;
                            r_state  <= S_RDWAIT;
                        end
                    end
                end
                S_RDWAIT: begin
                    if (MEM_RVALID) begin
                        r_state <= S_IDLE;
                    end else if (r_to_cnt == 8'(RD_TIMEOUT - 1)) begin
                        r_arb_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Accept and read-data strobes follow the controller directly so no cycle is lost
    assign w_ack_ok  = (r_state == S_ISSUE) & MEM_ACK;
    assign w_rv_ok   = (r_state == S_RDWAIT) & MEM_RVALID;

    assign R0_ACK    = w_ack_ok & (r_grant == 2'd0);
    assign R1_ACK    = w_ack_ok & (r_grant == 2'd1);
    assign R2_ACK    = w_ack_ok & (r_grant == 2'd2);
    assign R0_RVALID = w_rv_ok & (r_grant == 2'd0);
    assign R1_RVALID = w_rv_ok & (r_grant == 2'd1);
    assign R2_RVALID = w_rv_ok & (r_grant == 2'd2);
    assign R_RDATA   = MEM_RDATA;

    assign MEM_REQ   = r_mem_req;
    assign MEM_WR    = r_mem_wr;
    assign MEM_ADDR  = r_mem_addr;
    assign MEM_WDATA = r_mem_wdata;
    assign ARB_ERR   = r_arb_err;

`ifdef DE0EC8_ARB_STAT_EN
    logic [15:0] r_stat_g0;
    logic [15:0] r_stat_g1;
    logic [15:0] r_stat_g2;

    // Per-requester grant counters, free-running and wrapping
    always_ff @(posedge CLK50 or negedge RST_N_r) begin
        if (!RST_N_r) begin
            r_stat_g0 <= 16'd0;
            r_stat_g1 <= 16'd0;
            r_stat_g2 <= 16'd0;
        end else if ((r_state == S_IDLE) && w_any) begin
            case (w_sel)
                2'd1:    r_stat_g1 <= r_stat_g1 + 16'd1;
                2'd2:    r_stat_g2 <= r_stat_g2 + 16'd1;
                default: r_stat_g0 <= r_stat_g0 + 16'd1;
            endcase
        end
    end

    assign STAT_G0 = r_stat_g0;
    assign STAT_G1 = r_stat_g1;
    assign STAT_G2 = r_stat_g2;
`endif

endmodule
